// File: rtl/htif_mailbox_if.sv
// rtl/htif_mailbox_if.sv - CPU data-bus view of the htif mailbox (store strobe, address, data, read-back)
interface htif_mailbox_if;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        hit;

    modport master (
        output mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata, hit
    );

    modport slave (
        input  mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata, hit
    );
endinterface

// File: rtl/htif_mailbox.sv
// rtl/htif_mailbox.sv - tohost/fromhost mailbox responder with cycle budget and console FIFO
// Console FIFO and CONSOLE_ADDR decode are built only when HTIF_CONSOLE_EN is defined.
module htif_mailbox #(
    parameter logic [31:0] TOHOST_ADDR   = 32'h00001000,
    parameter logic [31:0] FROMHOST_ADDR = 32'h00001040,
    parameter logic [31:0] CONSOLE_ADDR  = 32'h00001080,
    parameter int          MAX_CYCLES    = 200000,
    parameter int          CON_DEPTH     = 8
) (
    input  logic          clk,
    input  logic          reset,
    htif_mailbox_if.slave bus,
    input  logic          host_fh_we,
    input  logic [31:0]   host_fh_data,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [31:0]   fail_code,
    output logic          timeout,
    output logic [31:0]   cycle_count,
    output logic          con_valid,
    output logic [7:0]    con_data,
    input  logic          con_ready,
    output logic          con_overflow
);

    typedef enum logic [1:0] {
        RUN,
        DONE,
        TIMEOUT
    } state_t;

    localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic        finish;
    logic [31:0] tohost;
    logic [31:0] fromhost;
    logic [31:0] tohost_merged;
    logic [31:0] fromhost_merged;
    logic [29:0] word;
    logic        hit_to;
    logic        hit_fh;
    logic        hit_con;
    logic        tohost_wr;
    logic        fromhost_wr;
    logic [31:0] con_status;
    logic        unused_addr;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Byte offset within the word never participates in decode.
    assign word        = bus.mem_addr[31:2];
    assign unused_addr = ^bus.mem_addr[1:0];
    assign hit_to      = (word == TOHOST_ADDR[31:2]);
    assign hit_fh      = (word == FROMHOST_ADDR[31:2]);
    assign bus.hit     = hit_to | hit_fh | hit_con;

    assign tohost_wr       = bus.mem_we && hit_to;
    assign fromhost_wr     = bus.mem_we && hit_fh;
    assign tohost_merged   = merge_lanes(tohost, bus.mem_wdata, bus.mem_wmask);
    assign fromhost_merged = merge_lanes(fromhost, bus.mem_wdata, bus.mem_wmask);

    always_ff @(posedge clk) begin
        if (!reset) state <= RUN;
        else        state <= next_state;
    end

    // A finishing store takes priority over the budget expiring on the same cycle.
    always_comb begin
        next_state = state;
        finish     = 1'b0;
        case (state)
            RUN: begin
                if (tohost_wr && (tohost_merged != 32'd0)) begin
                    next_state = DONE;
                    finish     = 1'b1;
                end else if (cycle_count == LAST_CYCLE) begin
                    next_state = TIMEOUT;
                end
            end
            DONE:    next_state = DONE;
            TIMEOUT: next_state = TIMEOUT;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tohost      <= 32'd0;
            fromhost    <= 32'd0;
            cycle_count <= 32'd0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= 32'd0;
        end else begin
            if (state == RUN && tohost_wr) tohost <= tohost_merged;
            // The count freezes on the edge that leaves RUN.
            if (state == RUN && next_state == RUN) cycle_count <= cycle_count + 32'd1;
            if (finish) begin
                pass      <= (tohost_merged == 32'd1);
                fail      <= (tohost_merged != 32'd1);
                fail_code <= tohost_merged;
            end
            if (host_fh_we)       fromhost <= host_fh_data;
            else if (fromhost_wr) fromhost <= fromhost_merged;
        end
    end

    assign done    = (state == DONE);
    assign timeout = (state == TIMEOUT);

    always_comb begin
        bus.mem_rdata = 32'd0;
        if (hit_to)       bus.mem_rdata = tohost;
        else if (hit_fh)  bus.mem_rdata = fromhost;
        else if (hit_con) bus.mem_rdata = con_status;
    end

`ifdef HTIF_CONSOLE_EN
    localparam int PW = $clog2(CON_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    fifo_mem [CON_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push_ok;
    logic          pop;

    assign hit_con    = (word == CONSOLE_ADDR[31:2]);
    assign fifo_full  = (fifo_count == CW'(CON_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push_req   = bus.mem_we && hit_con && bus.mem_wmask[0];
    // Full is judged before this cycle's pop, so a push into a full FIFO drops.
    assign push_ok    = push_req && !fifo_full;
    assign pop        = !fifo_empty && con_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            con_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push_ok) - CW'(pop);
            if (push_req && fifo_full) con_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
    end

    assign con_valid  = !fifo_empty;
    assign con_data   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    assign con_status = {30'd0, con_overflow, fifo_full};
`else
    logic unused_con;

    assign hit_con      = 1'b0;
    assign con_valid    = 1'b0;
    assign con_data     = 8'h00;
    assign con_overflow = 1'b0;
    assign con_status   = 32'd0;
    assign unused_con   = ^{con_ready, CONSOLE_ADDR, 32'(CON_DEPTH)};
`endif

endmodule

// File: tb/tb_htif_mailbox.sv
// tb/tb_htif_mailbox.sv - randomized self-checking bench for htif_mailbox against a behavioural model
module tb_htif_mailbox;

    localparam int          MAXC  = 50;
    localparam int          DEPTH = 8;
    localparam logic [31:0] TO_A  = 32'h00001000;
    localparam logic [31:0] FH_A  = 32'h00001040;
    localparam logic [31:0] CON_A = 32'h00001080;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        host_fh_we;
    logic [31:0] host_fh_data;
    logic        done, pass, fail, timeout;
    logic [31:0] fail_code, cycle_count;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        con_overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_tohost, m_fromhost, m_code;
    int          m_cycles;
    bit          m_done, m_pass, m_fail, m_timeout, m_ovf;
    logic [7:0]  m_q[$];

    always #5 clk = ~clk;

    htif_mailbox_if bus_if();

    htif_mailbox #(
        .TOHOST_ADDR  (TO_A),
        .FROMHOST_ADDR(FH_A),
        .CONSOLE_ADDR (CON_A),
        .MAX_CYCLES   (MAXC),
        .CON_DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .host_fh_we  (host_fh_we),
        .host_fh_data(host_fh_data),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .fail_code   (fail_code),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .con_valid   (con_valid),
        .con_data    (con_data),
        .con_ready   (con_ready),
        .con_overflow(con_overflow)
    );

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] mask);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (mask[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    task automatic set_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask);
        bus_if.mem_we    = we;
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = wdata;
        bus_if.mem_wmask = mask;
    endtask

    task automatic idle_inputs();
        set_bus(1'b0, 32'd0, 32'd0, 4'd0);
        host_fh_we   = 1'b0;
        host_fh_data = 32'd0;
        con_ready    = 1'b0;
    endtask

    // Advance one clock, evolving the model from the inputs presented this cycle.
    task automatic tick();
        logic [31:0] merged;
        bit          cw, pop;
        if (!m_done && !m_timeout) begin
            if (bus_if.mem_we && bus_if.mem_addr[31:2] == TO_A[31:2]) begin
                merged   = lane_merge(m_tohost, bus_if.mem_wdata, bus_if.mem_wmask);
                m_tohost = merged;
                if (merged != 32'd0) begin
                    m_done = 1; m_pass = (merged == 32'd1); m_fail = (merged != 32'd1); m_code = merged;
                end
            end
            if (!m_done) begin
                if (m_cycles == MAXC - 1) m_timeout = 1;
                else m_cycles++;
            end
        end
        if (host_fh_we) m_fromhost = host_fh_data;
        else if (bus_if.mem_we && bus_if.mem_addr[31:2] == FH_A[31:2])
            m_fromhost = lane_merge(m_fromhost, bus_if.mem_wdata, bus_if.mem_wmask);
`ifdef HTIF_CONSOLE_EN
        pop = con_ready && (m_q.size() > 0);
        cw  = bus_if.mem_we && bus_if.mem_addr[31:2] == CON_A[31:2] && bus_if.mem_wmask[0];
        if (cw && m_q.size() == DEPTH) m_ovf = 1;
        else if (cw) m_q.push_back(bus_if.mem_wdata[7:0]);
        if (pop) void'(m_q.pop_front());
`else
        cw = 0; pop = 0;
        if (cw || pop) m_ovf = 1;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        idle_inputs();
        repeat (n) begin @(posedge clk); #1; end
        m_tohost = 0; m_fromhost = 0; m_code = 0; m_cycles = 0;
        m_done = 0; m_pass = 0; m_fail = 0; m_timeout = 0; m_ovf = 0;
        m_q.delete();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if ({done, pass, fail, timeout, con_valid, con_overflow} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b need 000000", {done, pass, fail, timeout, con_valid, con_overflow});
        end
        checks++;
        if (fail_code !== 32'd0 || cycle_count !== 32'd0) begin
            errors++; $display("FAIL reset_counts: got code=%0d cyc=%0d need 0 0", fail_code, cycle_count);
        end
        repeat (5) tick();
        checks++;
        if (cycle_count !== 32'(m_cycles)) begin
            errors++; $display("FAIL reset_count_run: got %0d need %0d", cycle_count, m_cycles);
        end
    endtask

    task automatic test_pass();
        do_reset(2);
        set_bus(1'b1, TO_A, 32'd1, 4'hF);
        tick();
        idle_inputs();
        checks++;
        if ({done, pass, fail} !== {m_done, m_pass, m_fail} || fail_code !== m_code) begin
            errors++; $display("FAIL pass_result: got dpf=%b code=%0d need %b %0d", {done, pass, fail}, fail_code, {m_done, m_pass, m_fail}, m_code);
        end
        repeat (3) tick();
        checks++;
        if (cycle_count !== 32'(m_cycles)) begin
            errors++; $display("FAIL pass_freeze: got %0d need %0d", cycle_count, m_cycles);
        end
    endtask

    task automatic test_fail();
        do_reset(1);
        repeat (2) tick();
        set_bus(1'b1, TO_A, 32'd7, 4'hF);
        tick();
        checks++;
        if ({done, pass, fail} !== {m_done, m_pass, m_fail} || fail_code !== m_code) begin
            errors++; $display("FAIL fail_result: got dpf=%b code=%0d need %b %0d", {done, pass, fail}, fail_code, {m_done, m_pass, m_fail}, m_code);
        end
        set_bus(1'b1, TO_A, 32'd1, 4'hF);
        tick();
        checks++;
        if (pass !== m_pass || fail !== m_fail || fail_code !== m_code) begin
            errors++; $display("FAIL fail_ignore_later: got pass=%b code=%0d need %b %0d", pass, fail_code, m_pass, m_code);
        end
        set_bus(1'b0, TO_A | 32'($urandom_range(0, 3)), 32'd0, 4'h0);
        #1;
        checks++;
        if (bus_if.hit !== 1'b1 || bus_if.mem_rdata !== m_tohost) begin
            errors++; $display("FAIL fail_tohost_read: got hit=%b data=%h need 1 %h", bus_if.hit, bus_if.mem_rdata, m_tohost);
        end
        idle_inputs();
    endtask

    task automatic test_byte_merge();
        logic [31:0] d;
        do_reset(1);
        set_bus(1'b1, TO_A, 32'd0, 4'hF);
        tick();
        checks++;
        if (done !== m_done || timeout !== m_timeout) begin
            errors++; $display("FAIL merge_zero_store: got done=%b need %b", done, m_done);
        end
        set_bus(1'b1, TO_A, 32'hFFFFFF01, 4'b0001);
        tick();
        checks++;
        if ({done, pass, fail} !== {m_done, m_pass, m_fail} || fail_code !== m_code) begin
            errors++; $display("FAIL merge_byte: got dpf=%b code=%h need %b %h", {done, pass, fail}, fail_code, {m_done, m_pass, m_fail}, m_code);
        end
        for (int t = 0; t < 25; t++) begin
            do_reset(1);
            repeat ($urandom_range(0, 4)) tick();
            for (int w = 0; w < 3; w++) begin
                case ($urandom_range(0, 3))
                    0: d = 32'd0;
                    1: d = 32'd1;
                    2: d = 32'(1) << (8 * $urandom_range(0, 3));
                    default: d = $urandom;
                endcase
                set_bus(1'b1, TO_A | 32'($urandom_range(0, 3)), d, 4'($urandom_range(0, 15)));
                tick();
                idle_inputs();
                checks++;
                if ({done, pass, fail} !== {m_done, m_pass, m_fail} || fail_code !== m_code ||
                    cycle_count !== 32'(m_cycles)) begin
                    errors++; $display("FAIL merge_rand t=%0d w=%0d: got dpf=%b code=%h cyc=%0d need %b %h %0d",
                        t, w, {done, pass, fail}, fail_code, cycle_count, {m_done, m_pass, m_fail}, m_code, m_cycles);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset(1);
        repeat (MAXC + 3) tick();
        checks++;
        if (timeout !== m_timeout || done !== m_done || cycle_count !== 32'(m_cycles) || m_cycles != MAXC - 1) begin
            errors++; $display("FAIL timeout_expire: got to=%b done=%b cyc=%0d need %b %b %0d", timeout, done, cycle_count, m_timeout, m_done, m_cycles);
        end
        set_bus(1'b1, TO_A, 32'd1, 4'hF);
        tick();
        idle_inputs();
        checks++;
        if (done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_terminal: got done=%b pass=%b to=%b need 0 0 1", done, pass, timeout);
        end
        do_reset(1);
        repeat (MAXC - 1) tick();
        set_bus(1'b1, TO_A, 32'd1, 4'hF);
        tick();
        idle_inputs();
        tick();
        checks++;
        if (done !== m_done || timeout !== m_timeout || pass !== m_pass || cycle_count !== 32'(m_cycles) || !m_done) begin
            errors++; $display("FAIL timeout_finish_wins: got done=%b to=%b cyc=%0d need %b %b %0d", done, timeout, cycle_count, m_done, m_timeout, m_cycles);
        end
    endtask

    task automatic test_fromhost();
        do_reset(1);
        host_fh_we = 1'b1; host_fh_data = 32'hDEAD;
        set_bus(1'b1, FH_A, 32'd0, 4'hF);
        tick();
        idle_inputs();
        set_bus(1'b0, FH_A, 32'd0, 4'h0);
        #1;
        checks++;
        if (bus_if.hit !== 1'b1 || bus_if.mem_rdata !== 32'hDEAD) begin
            errors++; $display("FAIL fh_host_wins: got hit=%b data=%h need 1 0000dead", bus_if.hit, bus_if.mem_rdata);
        end
        for (int t = 0; t < 30; t++) begin
            host_fh_we   = ($urandom_range(0, 3) == 0);
            host_fh_data = $urandom;
            set_bus($urandom_range(0, 1) == 1, FH_A | 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
            tick();
            idle_inputs();
            set_bus(1'b0, FH_A | 32'($urandom_range(0, 3)), 32'd0, 4'h0);
            #1;
            checks++;
            if (bus_if.hit !== 1'b1 || bus_if.mem_rdata !== m_fromhost) begin
                errors++; $display("FAIL fh_rand t=%0d: got hit=%b data=%h need 1 %h", t, bus_if.hit, bus_if.mem_rdata, m_fromhost);
            end
        end
        set_bus(1'b0, 32'h00002000, 32'd0, 4'h0);
        #1;
        checks++;
        if (bus_if.hit !== 1'b0 || bus_if.mem_rdata !== 32'd0) begin
            errors++; $display("FAIL unmapped_read: got hit=%b data=%h need 0 0", bus_if.hit, bus_if.mem_rdata);
        end
        idle_inputs();
    endtask

    task automatic test_console();
`ifdef HTIF_CONSOLE_EN
        logic [31:0] status_exp;
        do_reset(1);
        for (int i = 0; i < 9; i++) begin
            set_bus(1'b1, CON_A, 32'h41 + 32'(i), 4'b0001);
            tick();
        end
        idle_inputs();
        status_exp = {30'd0, m_ovf, (m_q.size() == DEPTH)};
        set_bus(1'b0, CON_A, 32'd0, 4'h0);
        #1;
        checks++;
        if (con_overflow !== m_ovf || bus_if.mem_rdata !== status_exp || status_exp !== 32'h3) begin
            errors++; $display("FAIL con_overflow: got ovf=%b status=%h need %b %h", con_overflow, bus_if.mem_rdata, m_ovf, status_exp);
        end
        idle_inputs();
        con_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            checks++;
            if (con_valid !== (m_q.size() > 0) || con_data !== (m_q.size() > 0 ? m_q[0] : 8'h00)) begin
                errors++; $display("FAIL con_drain i=%0d: got v=%b d=%h need %b %h", i, con_valid, con_data, m_q.size() > 0, m_q.size() > 0 ? m_q[0] : 8'h00);
            end
            tick();
        end
        do_reset(1);
        for (int t = 0; t < 80; t++) begin
            set_bus($urandom_range(0, 1) == 1, CON_A, $urandom, 4'($urandom_range(0, 15)));
            con_ready = ($urandom_range(0, 2) == 0);
            tick();
            checks++;
            if (con_valid !== (m_q.size() > 0) || con_data !== (m_q.size() > 0 ? m_q[0] : 8'h00) || con_overflow !== m_ovf) begin
                errors++; $display("FAIL con_rand t=%0d: got v=%b d=%h o=%b need %b %h %b", t, con_valid, con_data, con_overflow,
                    m_q.size() > 0, m_q.size() > 0 ? m_q[0] : 8'h00, m_ovf);
            end
        end
        idle_inputs();
`else
        do_reset(1);
        set_bus(1'b1, CON_A, 32'h41, 4'hF);
        #1;
        checks++;
        if (bus_if.hit !== 1'b0 || bus_if.mem_rdata !== 32'd0) begin
            errors++; $display("FAIL con_disabled_decode: got hit=%b data=%h need 0 0", bus_if.hit, bus_if.mem_rdata);
        end
        con_ready = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if ({con_valid, con_overflow} !== 2'b00 || con_data !== 8'h00) begin
            errors++; $display("FAIL con_disabled_out: got v=%b o=%b d=%h need 0 0 00", con_valid, con_overflow, con_data);
        end
`endif
    endtask

    task automatic test_midrun_reset();
        do_reset(1);
        repeat ($urandom_range(3, 10)) tick();
        host_fh_we = 1'b1; host_fh_data = $urandom | 32'd1;
        set_bus(1'b1, CON_A, 32'h5A, 4'h1);
        tick();
        idle_inputs();
        set_bus(1'b1, TO_A, 32'd5, 4'hF);
        tick();
        idle_inputs();
        do_reset(2);
        checks++;
        if ({done, pass, fail, timeout, con_valid, con_overflow} !== 6'b0 || fail_code !== 32'd0 || cycle_count !== 32'd0) begin
            errors++; $display("FAIL midrun_reset: got flags=%b code=%0d cyc=%0d need 0", {done, pass, fail, timeout, con_valid, con_overflow}, fail_code, cycle_count);
        end
        set_bus(1'b0, FH_A, 32'd0, 4'h0);
        #1;
        checks++;
        if (bus_if.mem_rdata !== m_fromhost) begin
            errors++; $display("FAIL midrun_fromhost: got %h need %h", bus_if.mem_rdata, m_fromhost);
        end
        set_bus(1'b0, TO_A, 32'd0, 4'h0);
        #1;
        checks++;
        if (bus_if.mem_rdata !== m_tohost) begin
            errors++; $display("FAIL midrun_tohost: got %h need %h", bus_if.mem_rdata, m_tohost);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_pass();
        test_fail();
        test_byte_merge();
        test_timeout();
        test_fromhost();
        test_console();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
